shift_register_univ: RTL and testbench
======================================

// Module: shift_register_univ
// PURPOSE
//  WIDTH-bit universal shift register built from D-type storage stages; sits
//  directly downstream of the single-bit D flip-flop stage and chains its
//  behaviour into a word. Supports hold, shift right, shift left and parallel
//  load. A shift counter flags each completed WIDTH-bit serial word, so the
//  block can serve as a serializer or deserializer for the next lab stage.
// PARAMETERS
//  WIDTH    4   register width in bits; legal range 2..16
//  CNT_W    $clog2(WIDTH+1)   shift-counter width; derived, not overridden
// PORTS
//  clk          in   1        clock; all state updates on the FALLING edge
//  clear        in   1        synchronous reset, active-high
//  preset       in   1        synchronous set-all-ones, active-high
//  mode         in   2        00 hold, 01 shift right, 10 shift left, 11 load
//  ser_in_r     in   1        serial input entering at MSB on shift right
//  ser_in_l     in   1        serial input entering at LSB on shift left
//  D            in   WIDTH    parallel load data
//  Q            out  WIDTH    register contents
//  QNot         out  WIDTH    bitwise complement of Q, always ~Q
//  ser_out_r    out  1        Q[0], the bit shifted out on shift right
//  ser_out_l    out  1        Q[WIDTH-1], the bit shifted out on shift left
//  shift_cnt    out  CNT_W    shifts since last clear/preset/load, 0..WIDTH-1
//  word_done    out  1        one-cycle pulse after the WIDTH-th shift
// BEHAVIOUR
//  - Priority per falling edge: clear > preset > mode. clear and preset
//    together: clear wins (deterministic, no X).
//  - clear: Q=0, QNot=all ones, shift_cnt=0, word_done=0.
//  - preset: Q=all ones, QNot=0, shift_cnt=0, word_done=0.
//  - mode 00 hold: Q and shift_cnt unchanged; word_done=0.
//  - mode 01 shift right: Q <= {ser_in_r, Q[WIDTH-1:1]}.
//  - mode 10 shift left: Q <= {Q[WIDTH-2:0], ser_in_l}.
//  - mode 11 load: Q <= D; shift_cnt=0; word_done=0.
//  - Counter, on every shift edge (mode 01 or 10):
//    if shift_cnt==WIDTH-1, then shift_cnt<=0 and word_done<=1;
//    otherwise shift_cnt<=shift_cnt+1 and word_done<=0.
//  - word_done is registered. It is high for exactly the one clock period
//    after the edge that completed the word. It clears on any non-completing
//    edge. Back-to-back words give one pulse every WIDTH shifts.
//  - Mixing left and right shifts inside one word is legal; every shift
//    counts regardless of direction.
//  - Latency: Q, shift_cnt and word_done are valid after the falling edge
//    that samples the inputs. ser_out_* and QNot are combinational from Q.
//  - Reset mid-word: clear or preset discards the partial count. No
//    word_done is produced for the aborted word.
//  - After power-up and before the first clear, state is undefined. The
//    bench must apply clear first.
// TESTING
//  1. clear=1 for 1 edge -> Q=0000, QNot=1111, shift_cnt=0, word_done=0.
//  2. Load D=1011 (mode 11), then 4 shifts right with ser_in_r=0
//     -> Q: 0101, 0010, 0001, 0000; ser_out_r before each edge: 1,1,0,1;
//     word_done=1 only after the 4th edge.
//  3. From clear, 8 shifts left with ser_in_l=1,0,1,1,0,0,1,0
//     -> after edge 4 Q=1011 and word_done pulses; after edge 8 Q=0010
//     and word_done pulses again; shift_cnt wraps 3->0.
//  4. Load 0110, shift twice, hold 3 edges, shift twice
//     -> shift_cnt stays 2 during hold; word_done only after the 4th shift.
//  5. clear=1 and preset=1 together -> Q=0000 (clear wins). preset alone
//     with mode=11 and D=0101 -> Q=1111.
//  6. 3 shifts, then clear, then 4 shifts -> no pulse after the 3rd shift;
//     a single word_done after the 4th shift following clear.

Source files
------------

// File: rtl/shift_register_univ.sv
// -----------------------------------------------------------------------------
// shift_register_univ
//
// WIDTH-bit universal shift register with hold, shift right, shift left and
// parallel load. Every shift in either direction advances a word counter. The
// counter raises word_done for one clock period after each WIDTH-th shift,
// which lets the block act as a serializer or a deserializer.
//
// All state changes on the FALLING edge of clk. clear and preset are
// synchronous. clear takes priority over preset, and both take priority over
// mode.
//
// Ports
//   clk        in   1      clock; state updates on the falling edge
//   clear      in   1      synchronous clear, active-high (highest priority)
//   preset     in   1      synchronous set-all-ones, active-high
//   mode       in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   ser_in_r   in   1      serial bit entering at the MSB on shift right
//   ser_in_l   in   1      serial bit entering at the LSB on shift left
//   D          in   WIDTH  parallel load data
//   Q          out  WIDTH  register contents
//   QNot       out  WIDTH  bitwise complement of Q
//   ser_out_r  out  1      Q[0], the bit that leaves on shift right
//   ser_out_l  out  1      Q[WIDTH-1], the bit that leaves on shift left
//   shift_cnt  out  CNT_W  shifts since the last clear/preset/load, 0..WIDTH-1
//   word_done  out  1      one-period pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module shift_register_univ #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QNot,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Advance the word counter by one shift. Bit 0 of the result is the
    // completion flag. The upper bits hold the new count, which wraps to zero
    // on the shift that finishes a word.
    function automatic logic [CNT_W:0] count_step(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] res;
        if (cnt == CNT_LAST) begin
            res = {CNT_ZERO, 1'b1};
        end else begin
            res = {cnt + CNT_ONE, 1'b0};
        end
        return res;
    endfunction

    mode_e            mode_s;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;

    logic [WIDTH-1:0] q_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_nxt_s;
    logic [CNT_W:0]   step_s;

    assign mode_s = mode_e'(mode);
    assign step_s = count_step(cnt_r);

    // Next-state selection. Priority is clear, then preset, then mode.
    // Any edge that is not a completing shift drives word_done low.
    always_comb begin
        q_nxt_s    = q_r;
        cnt_nxt_s  = cnt_r;
        done_nxt_s = 1'b0;
        if (clear) begin
            q_nxt_s    = {WIDTH{1'b0}};
            cnt_nxt_s  = CNT_ZERO;
            done_nxt_s = 1'b0;
        end else if (preset) begin
            q_nxt_s    = {WIDTH{1'b1}};
            cnt_nxt_s  = CNT_ZERO;
            done_nxt_s = 1'b0;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    q_nxt_s    = q_r;
                    cnt_nxt_s  = cnt_r;
                    done_nxt_s = 1'b0;
                end
                MODE_SHR: begin
                    q_nxt_s    = {ser_in_r, q_r[WIDTH-1:1]};
                    cnt_nxt_s  = step_s[CNT_W:1];
                    done_nxt_s = step_s[0];
                end
                MODE_SHL: begin
                    q_nxt_s    = {q_r[WIDTH-2:0], ser_in_l};
                    cnt_nxt_s  = step_s[CNT_W:1];
                    done_nxt_s = step_s[0];
                end
                MODE_LOAD: begin
                    q_nxt_s    = D;
                    cnt_nxt_s  = CNT_ZERO;
                    done_nxt_s = 1'b0;
                end
                default: begin
                    q_nxt_s    = q_r;
                    cnt_nxt_s  = cnt_r;
                    done_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State register, updated on the falling edge of clk.
    always_ff @(negedge clk) begin
        q_r    <= q_nxt_s;
        cnt_r  <= cnt_nxt_s;
        done_r <= done_nxt_s;
    end

    assign Q         = q_r;
    assign QNot      = ~q_r;
    assign ser_out_r = q_r[0];
    assign ser_out_l = q_r[WIDTH-1];
    assign shift_cnt = cnt_r;
    assign word_done = done_r;

endmodule

// File: tb/tb_shift_register_univ.sv
module tb_shift_register_univ;

    localparam int W     = 4;
    localparam int CNT_W = $clog2(W + 1);

    logic             clk;
    logic             clear;
    logic             preset;
    logic [1:0]       mode;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [W-1:0]     D;
    logic [W-1:0]     Q;
    logic [W-1:0]     QNot;
    logic             ser_out_r;
    logic             ser_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the word value as an integer, plus the number of shifts
    // taken since the last clear/preset/load.
    int  m_val;
    int  m_shifts;
    bit  m_done;
    bit  m_valid = 1'b0;

    shift_register_univ #(.WIDTH(W)) dut (
        .clk       (clk),
        .clear     (clear),
        .preset    (preset),
        .mode      (mode),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .D         (D),
        .Q         (Q),
        .QNot      (QNot),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int mask;
        mask = (1 << W) - 1;
        chk("Q",         32'(Q),         32'(m_val));
        chk("QNot",      32'(QNot),      32'((~m_val) & mask));
        chk("ser_out_r", 32'(ser_out_r), 32'(m_val % 2));
        chk("ser_out_l", 32'(ser_out_l), 32'((m_val >> (W - 1)) % 2));
        chk("shift_cnt", 32'(shift_cnt), 32'(m_shifts));
        chk("word_done", 32'(word_done), 32'(m_done));
    endtask

    // Applies one set of inputs across a falling edge, advances the model and
    // checks every output. Each call starts just after a rising edge.
    task automatic step(input logic c, input logic p, input logic [1:0] md,
                        input logic sr, input logic sl, input logic [W-1:0] d);
        int mask;
        mask = (1 << W) - 1;
        if (m_valid) begin
            chk("ser_out_r_pre", 32'(ser_out_r), 32'(m_val % 2));
        end
        clear = c; preset = p; mode = md; ser_in_r = sr; ser_in_l = sl; D = d;
        @(negedge clk);
        if (c) begin
            m_val = 0; m_shifts = 0; m_done = 1'b0; m_valid = 1'b1;
        end else if (p) begin
            m_val = mask; m_shifts = 0; m_done = 1'b0;
        end else if (md == 2'd3) begin
            m_val = int'(d); m_shifts = 0; m_done = 1'b0;
        end else if (md == 2'd0) begin
            m_done = 1'b0;
        end else begin
            if (md == 2'd1) m_val = (m_val / 2) + (int'(sr) << (W - 1));
            else            m_val = ((m_val * 2) & mask) + int'(sl);
            m_shifts = m_shifts + 1;
            m_done   = (m_shifts == W);
            m_shifts = m_shifts % W;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        logic [7:0] pat;
        clear = 1'b0; preset = 1'b0; mode = 2'b00;
        ser_in_r = 1'b0; ser_in_l = 1'b0; D = '0;
        @(posedge clk);
        #1;

        // Test 1: clear establishes the reset state.
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        chk("t1_Q", 32'(Q), 32'h0);
        chk("t1_QNot", 32'(QNot), 32'hF);

        // Test 2: load 1011, then four right shifts with zero fill.
        step(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
        chk("t2_Q", 32'(Q), 32'h0);
        chk("t2_done", 32'(word_done), 32'h1);

        // Test 3: eight left shifts starting from clear; two word pulses.
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 2'b10, 1'b0, pat[7 - i], 4'h0);
            if (i == 3) begin
                chk("t3_Q4", 32'(Q), 32'hB);
                chk("t3_done4", 32'(word_done), 32'h1);
            end
        end
        chk("t3_Q8", 32'(Q), 32'h2);
        chk("t3_done8", 32'(word_done), 32'h1);

        // Test 4: two shifts, three holds, then two more shifts.
        step(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'b0110);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        chk("t4_hold_cnt", 32'(shift_cnt), 32'h2);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'h0);
        chk("t4_done", 32'(word_done), 32'h1);

        // Test 5: clear beats preset; preset beats load.
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0101);
        chk("t5_clear_wins", 32'(Q), 32'h0);
        step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0101);
        chk("t5_preset", 32'(Q), 32'hF);

        // Test 6: clear in the middle of a word discards the partial count.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        chk("t6_no_pulse", 32'(word_done), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        chk("t6_done", 32'(word_done), 32'h1);

        // Random phase: mixed modes, with rare clear and preset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
